// File: rtl/dmg_timer.sv
// DMG timer/divider: free-running M-cycle divider (DIV) plus the programmable
// TIMA/TMA/TAC counter with its overflow/reload sequencing and interrupt pulse.
module dmg_timer #(
    parameter int unsigned CNT_W     = 14,
    parameter logic [2:0]  TAC_RESET = 3'b000
) (
    input  logic       c,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    localparam int unsigned DIV_W = 8;

    localparam logic [1:0] A_DIV  = 2'd0;
    localparam logic [1:0] A_TIMA = 2'd1;
    localparam logic [1:0] A_TMA  = 2'd2;
    localparam logic [1:0] A_TAC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_OVF    = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       tima;
    logic [7:0]       tima_nxt;
    logic [7:0]       tma;
    logic [7:0]       tma_nxt;
    logic [2:0]       tac;
    logic [2:0]       tac_nxt;
    logic             sig_q;
    logic             sig_nxt;
    logic             sel_bit;
    logic             fall;
    logic             irq_nxt;

    logic wr_div;
    logic wr_tima;
    logic wr_tma;
    logic wr_tac;

    // Register write decode
    always_comb begin
        wr_div  = wr && (addr == A_DIV);
        wr_tima = wr && (addr == A_TIMA);
        wr_tma  = wr && (addr == A_TMA);
        wr_tac  = wr && (addr == A_TAC);
    end

    // Divider and TAC next values; the timer input is taken from these so that
    // a DIV reset or TAC write that drops the selected bit produces an edge
    always_comb begin
        cnt_nxt = wr_div ? '0 : cnt + CNT_W'(1);
        tac_nxt = wr_tac ? din[2:0] : tac;
    end

    // Timer input select and falling-edge detect
    always_comb begin
        sel_bit = 1'b0;
        case (tac_nxt[1:0])
            2'b00:   sel_bit = cnt_nxt[7];
            2'b01:   sel_bit = cnt_nxt[1];
            2'b10:   sel_bit = cnt_nxt[3];
            2'b11:   sel_bit = cnt_nxt[5];
            default: sel_bit = 1'b0;
        endcase
        sig_nxt = tac_nxt[2] & sel_bit;
        fall    = sig_q & ~sig_nxt;
    end

    // State register
    always_ff @(posedge c) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the overflow/reload sequence
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (!wr_tima && fall && (tima == 8'hFF)) begin
                    state_nxt = ST_OVF;
                end
            end
            ST_OVF: begin
                state_nxt = wr_tima ? ST_RUN : ST_RELOAD;
            end
            ST_RELOAD: begin
                // A TMA write here lands in TIMA and takes precedence over an increment
                if (!wr_tma && fall && (tima == 8'hFF)) begin
                    state_nxt = ST_OVF;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Output/datapath next values driven by the current state
    always_comb begin
        tma_nxt  = wr_tma ? din : tma;
        tima_nxt = tima;
        irq_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                if (wr_tima) begin
                    tima_nxt = din;
                end else if (fall) begin
                    tima_nxt = tima + 8'd1;
                end
            end
            ST_OVF: begin
                // Edges are ignored here; a TIMA write aborts the reload and the interrupt
                if (wr_tima) begin
                    tima_nxt = din;
                end else begin
                    tima_nxt = tma_nxt;
                    irq_nxt  = 1'b1;
                end
            end
            ST_RELOAD: begin
                // TIMA writes are dropped; TMA writes pass through to TIMA
                if (wr_tma) begin
                    tima_nxt = din;
                end else if (fall) begin
                    tima_nxt = tima + 8'd1;
                end
            end
            default: tima_nxt = tima;
        endcase
    end

    // Datapath registers
    always_ff @(posedge c) begin
        if (reset) begin
            cnt   <= '0;
            tima  <= 8'h00;
            tma   <= 8'h00;
            tac   <= TAC_RESET;
            sig_q <= 1'b0;
            irq   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            tima  <= tima_nxt;
            tma   <= tma_nxt;
            tac   <= tac_nxt;
            sig_q <= sig_nxt;
            irq   <= irq_nxt;
        end
    end

    // CPU read mux
    always_comb begin
        dout = 8'h00;
        case (addr)
            A_DIV:   dout = cnt[CNT_W-1 -: DIV_W];
            A_TIMA:  dout = tima;
            A_TMA:   dout = tma;
            A_TAC:   dout = {5'b11111, tac};
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dmg_timer.sv
// Directed, table-driven bench for dmg_timer.
module tb_dmg_timer;

    logic       c;
    logic       reset;
    logic [1:0] addr;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       w;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [7:0] ed;
        logic       ei;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    dmg_timer #(.CNT_W(14), .TAC_RESET(3'b000)) dut (
        .c     (c),
        .reset (reset),
        .addr  (addr),
        .wr    (wr),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic r, logic w, logic [1:0] wa, logic [7:0] wd,
                                logic [1:0] ra, logic [7:0] ed, logic ei, string nm);
        vec_t v;
        v.rst = r; v.w = w; v.wa = wa; v.wd = wd;
        v.ra = ra; v.ed = ed; v.ei = ei; v.nm = nm;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic do_write(logic [1:0] a, logic [7:0] d);
        wr = 1'b1; addr = a; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd(string nm, logic [1:0] a, logic [7:0] exp);
        addr = a;
        #1;
        chk(nm, dout, exp);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; addr = 2'd0; din = 8'h00;

        // reset values, /4 overflow+reload, OVF TIMA-write cancel, OVF TMA pass-through,
        // RELOAD TIMA-write ignore, RUN write-vs-edge, RELOAD TMA pass-through, reset in OVF
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, "rst_div"));
        vecs.push_back(mk(1, 0, 0, 8'h00, 3, 8'hF8, 0, "rst_tac"));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, "rst_tima"));
        vecs.push_back(mk(1, 0, 0, 8'h00, 2, 8'h00, 0, "rst_tma"));
        vecs.push_back(mk(0, 1, 2, 8'hA0, 2, 8'hA0, 0, "t2_wr_tma"));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hFF, 0, "t2_wr_tima"));
        vecs.push_back(mk(0, 1, 0, 8'h12, 0, 8'h00, 0, "t2_div_clr"));
        vecs.push_back(mk(0, 1, 3, 8'h05, 3, 8'hFD, 0, "t2_wr_tac"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "t2_hold1"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "t2_hold2"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "t2_ovf_zero"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hA0, 1, "t2_reload"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hA0, 0, "t2_irq_drop"));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hFF, 0, "t3_wr_tima"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "t3_ovf_zero"));
        vecs.push_back(mk(0, 1, 1, 8'h33, 1, 8'h33, 0, "t3_ovf_wr"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h33, 0, "t3_no_reload"));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hFF, 0, "t4_wr_tima"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "t4_ovf_zero"));
        vecs.push_back(mk(0, 1, 2, 8'h55, 1, 8'h55, 1, "t4_ovf_tma"));
        vecs.push_back(mk(0, 1, 1, 8'h77, 1, 8'h55, 0, "t4_reload_ign"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2, 8'h55, 0, "t4_tma"));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hFF, 0, "wr_beats_inc"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "r_hold1"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "r_hold2"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "r_hold3"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "r_ovf_zero"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h55, 1, "r_reload"));
        vecs.push_back(mk(0, 1, 2, 8'h66, 1, 8'h66, 0, "r_tma_thru"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2, 8'h66, 0, "r_tma"));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hFF, 0, "t6_wr_tima"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "t6_hold1"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "t6_hold2"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'hFF, 0, "t6_hold3"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "t6_ovf_zero"));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, "t6_rst"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, "t6_no_reload"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2, 8'h00, 0, "t6_tma"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 3, 8'hF8, 0, "t6_tac"));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, "t6_div"));

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            wr    = vecs[i].w;
            addr  = vecs[i].wa;
            din   = vecs[i].wd;
            tick();
            wr    = 1'b0;
            addr  = vecs[i].ra;
            #1;
            chk(vecs[i].nm, dout, vecs[i].ed);
            chk({vecs[i].nm, "_irq"}, {7'b0, irq}, {7'b0, vecs[i].ei});
        end
        reset = 1'b0;

        // DIV write while the /256 tap is high counts as an edge; when low it does not
        begin
            bit found;
            found = 1'b0;
            do_write(2'd3, 8'h04);
            addr = 2'd0;
            for (int k = 0; k < 300; k++) begin
                tick();
                if (dout[1]) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL t5_wait: got DIV=%h expected bit1 set within 300 cycles", dout);
            end
            rd("t5_div_pre", 2'd0, 8'h02);
            rd("t5_tima_pre", 2'd1, 8'h00);
            do_write(2'd0, 8'hAB);
            rd("t5_div_clr", 2'd0, 8'h00);
            rd("t5_tima_inc", 2'd1, 8'h01);
            do_write(2'd0, 8'h00);
            rd("t5_div_clr2", 2'd0, 8'h00);
            rd("t5_tima_noinc", 2'd1, 8'h01);
        end

        // /4 rate over 16 cycles, upper TAC bits discarded, no interrupt
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_write(2'd3, 8'hFD);
        rd("t1_tac", 2'd3, 8'hFD);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t1_irq", {7'b0, irq}, 8'h00);
        end
        rd("t1_tima", 2'd1, 8'h04);
        rd("t1_div", 2'd0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
